io_debounce_edge: RTL and testbench
===================================

Name: io_debounce_edge

Overview:
- Parametrised input conditioner for board-level switches and buttons. It sits between the FPGA pads and the demo system's general-purpose inputs.
- Each channel is synchronised into the system clock domain, optionally inverted, and debounced by a per-channel stability counter.
- Each channel produces a clean level plus single-cycle rise and fall pulses. A combined any-edge pulse is provided for interrupt generation.
- Replaces direct wiring of raw switch and button pins to the GPIO inputs.

Parameters:
- NumCh, 8, number of independent input channels (≥1).
- SyncStages, 2, flops in each synchroniser chain (≥2).
- CntWidth, 16, width of each debounce counter.
- DebounceCycles, 50000, consecutive stable cycles required before accepting a new level. Range 1 ≤ DebounceCycles ≤ 2^CntWidth−1; elaboration-time assertion if violated.
- InvertMask, NumCh'(0), per-channel bit; 1 inverts that raw input before synchronisation (for active-low buttons).

Ports:
- clk_sys_i  input  1  system clock
- rst_sys_ni  input  1  reset, synchronous, active-low
- en_i  input  1  1 = debouncing active; 0 = freeze all channels
- raw_i  input  NumCh  asynchronous raw pad inputs
- level_o  output  NumCh  debounced level per channel
- rise_o  output  NumCh  1-cycle pulse when level_o goes 0→1
- fall_o  output  NumCh  1-cycle pulse when level_o goes 1→0
- any_edge_o  output  1  OR-reduction of rise_o | fall_o, same cycle

Behaviour:
- Reset:
  - Synchronous and active-low; only sampled on a rising clk_sys_i edge.
  - While rst_sys_ni=0 at an edge: all synchroniser flops, counters, level_o, rise_o and fall_o are cleared to 0; any_edge_o=0.
  - A reset asserted mid-count discards partial counts.
- Input path:
  - The synchroniser input is s_in = raw_i ^ InvertMask.
  - The synchroniser is a SyncStages-deep shift register; its last stage is s[c].
- Per-channel counter (one counter per channel, counter cnt[c]):
  - en_i=0: cnt held at 0, level_o held, no pulses. The synchroniser keeps running.
  - en_i=1 and s[c]==level_o[c]: cnt ← 0.
  - en_i=1, s[c]!=level_o[c], cnt<DebounceCycles−1: cnt ← cnt+1.
  - en_i=1, s[c]!=level_o[c], cnt==DebounceCycles−1: level_o[c] ← s[c]; cnt ← 0. Registered rise_o[c] (if new level 1) or fall_o[c] (if new level 0) is asserted for exactly the cycle in which the new level_o first appears.
- Glitch rejection: any return of s[c] to level_o[c] before the count completes resets cnt to 0. The next mismatch restarts counting from 0.
- Latency:
  - A raw change held steady is visible on level_o exactly SyncStages+DebounceCycles clock edges after the first edge that samples it.
  - The rise/fall pulse is coincident with that level change.
- DebounceCycles=1: level_o follows s one cycle later; no filtering.
- Channel independence: channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses; any_edge_o is a single-cycle 1.
- Counter safety: the counter never wraps; its maximum value is DebounceCycles−1.
- Pulse limits: rise_o and fall_o are never both 1 on one channel. A channel's pulses are never asserted on consecutive cycles unless DebounceCycles=1 and the input toggles every cycle.
- en_i timing: deasserting en_i mid-count clears the count next edge. Re-enabling restarts counting from 0.

Test Plan (NumCh=8, SyncStages=2, DebounceCycles=4, InvertMask=8'h0F):
- Reset, then raw_i=8'h0F held -> level_o stays 8'h00 (inverted idle); no pulses over 20 cycles. Assert rst_sys_ni=0 for 1 edge mid-run -> all outputs 0 the following cycle.
- raw_i[4] 0→1, held -> level_o[4]=1 and rise_o[4]=1 exactly 6 edges later; rise_o[4]=0 the cycle after; any_edge_o pulses identically.
- raw_i[5] 1-cycle and 3-cycle high glitches separated by 5 low cycles -> level_o[5] never changes; no pulses.
- raw_i[0] driven 1→0 (button press, inverted) -> level_o[0]=1 with rise_o[0] at +6. Release -> fall_o[0] at +6.
- raw_i[7:6] toggled on the same edge -> rise_o[7:6]=2'b11 in the same cycle; any_edge_o is a single 1-cycle pulse.
- en_i=0 while raw_i[4] changes, held 10 cycles -> no change. en_i=1 -> level_o[4] updates 4 edges after re-enable (synchroniser already settled).

Source files
------------

// File: rtl/io_debounce_edge_if.sv
// rtl/io_debounce_edge_if.sv - pad conditioner bus: enable, raw pads, debounced level and edge pulses
interface io_debounce_edge_if #(
   parameter int NumCh = 8
);
   logic             en_i;
   logic [NumCh-1:0] raw_i;
   logic [NumCh-1:0] level_o;
   logic [NumCh-1:0] rise_o;
   logic [NumCh-1:0] fall_o;
   logic             any_edge_o;

   // Consumer side: drives enable and raw pads, observes conditioned outputs
   modport master (
      output en_i,
      output raw_i,
      input  level_o,
      input  rise_o,
      input  fall_o,
      input  any_edge_o
   );

   // Conditioner side
   modport slave (
      input  en_i,
      input  raw_i,
      output level_o,
      output rise_o,
      output fall_o,
      output any_edge_o
   );
endinterface

// File: rtl/io_debounce_edge.sv
// rtl/io_debounce_edge.sv - per-channel synchroniser, optional inversion, debounce counter and edge pulses
module io_debounce_edge #(
   parameter int               NumCh          = 8,
   parameter int               SyncStages     = 2,
   parameter int               CntWidth       = 16,
   parameter int               DebounceCycles = 50000,
   parameter logic [NumCh-1:0] InvertMask     = NumCh'(0)
) (
   input logic               clk_sys_i,
   input logic               rst_sys_ni,
   io_debounce_edge_if.slave bus
);

   localparam longint LpCntLimit = (longint'(1) << CntWidth) - longint'(1);

   // Reject parameter sets the counter cannot represent or that break the synchroniser
   generate
      if (NumCh < 1 || SyncStages < 2 || DebounceCycles < 1 ||
          longint'(DebounceCycles) > LpCntLimit) begin : g_param_check
         $error("io_debounce_edge: illegal parameters");
      end
   endgenerate

   // Terminal count: a mismatch seen at this count is accepted as the new level
   localparam logic [CntWidth-1:0] LpCntMax = CntWidth'(DebounceCycles - 1);

   logic [NumCh-1:0]    w_s_in;
   logic [NumCh-1:0]    w_s;
   logic [NumCh-1:0]    r_sync [SyncStages];
   logic [CntWidth-1:0] r_cnt  [NumCh];
   logic [NumCh-1:0]    r_level;
   logic [NumCh-1:0]    r_rise;
   logic [NumCh-1:0]    r_fall;

   // Active-low buttons are flipped before the synchroniser so everything downstream is active-high
   assign w_s_in = bus.raw_i ^ InvertMask;
   assign w_s    = r_sync[SyncStages-1];

   // Synchroniser chain keeps running while en_i is low so re-enable sees a settled input
   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         for (int i = 0; i < SyncStages; i++) begin
            r_sync[i] <= '0;
         end
      end else begin
         r_sync[0] <= w_s_in;
         for (int i = 1; i < SyncStages; i++) begin
            r_sync[i] <= r_sync[i-1];
         end
      end
   end

   // Stability counters: count consecutive mismatches, accept the new level at terminal count
   always_ff @(posedge clk_sys_i) begin
      if (!rst_sys_ni) begin
         for (int c = 0; c < NumCh; c++) begin
            r_cnt[c] <= '0;
         end
         r_level <= '0;
         r_rise  <= '0;
         r_fall  <= '0;
      end else begin
         r_rise <= '0;
         r_fall <= '0;
         for (int c = 0; c < NumCh; c++) begin
            if (!bus.en_i) begin
               r_cnt[c] <= '0;
            end else if (w_s[c] == r_level[c]) begin
               r_cnt[c] <= '0;
            end else if (r_cnt[c] >= LpCntMax) begin
               // Pulse is registered alongside the level so both appear in the same cycle
               r_level[c] <= w_s[c];
               r_rise[c]  <= w_s[c];
               r_fall[c]  <= ~w_s[c];
               r_cnt[c]   <= '0;
            end else begin
               r_cnt[c] <= r_cnt[c] + CntWidth'(1);
            end
         end
      end
   end

   assign bus.level_o    = r_level;
   assign bus.rise_o     = r_rise;
   assign bus.fall_o     = r_fall;
   assign bus.any_edge_o = |(r_rise | r_fall);

endmodule

// File: tb/tb_io_debounce_edge.sv
// tb/tb_io_debounce_edge.sv - directed vector bench for io_debounce_edge
module tb_io_debounce_edge;

   localparam int         NumCh          = 8;
   localparam int         SyncStages     = 2;
   localparam int         CntWidth       = 16;
   localparam int         DebounceCycles = 4;
   localparam logic [7:0] InvertMask     = 8'h0F;

   logic clk = 1'b0;
   logic rstn;

   io_debounce_edge_if #(.NumCh(NumCh)) u_if ();

   io_debounce_edge #(
      .NumCh          (NumCh),
      .SyncStages     (SyncStages),
      .CntWidth       (CntWidth),
      .DebounceCycles (DebounceCycles),
      .InvertMask     (InvertMask)
   ) u_dut (
      .clk_sys_i  (clk),
      .rst_sys_ni (rstn),
      .bus        (u_if.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] raw;
      logic       en;
      logic       rstn;
      logic [7:0] lvl;
      logic [7:0] rise;
      logic [7:0] fall;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic add(input logic [7:0] raw, input logic en, input logic rn,
                      input logic [7:0] lvl, input logic [7:0] rise,
                      input logic [7:0] fall, input int rep);
      vec_t v;
      v.raw  = raw;
      v.en   = en;
      v.rstn = rn;
      v.lvl  = lvl;
      v.rise = rise;
      v.fall = fall;
      for (int i = 0; i < rep; i++) vecs.push_back(v);
   endtask

   task automatic step(input logic [7:0] raw, input logic en, input logic rn);
      u_if.raw_i = raw;
      u_if.en_i  = en;
      rstn       = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h expected %h", name, got, exp);
   endtask

   task automatic chk_all(input string tag, input logic [7:0] lvl,
                          input logic [7:0] rise, input logic [7:0] fall);
      chk8({tag, " level"}, u_if.level_o, lvl);
      chk8({tag, " rise"}, u_if.rise_o, rise);
      chk8({tag, " fall"}, u_if.fall_o, fall);
      chk8({tag, " any_edge"}, {7'd0, u_if.any_edge_o}, {7'd0, |(rise | fall)});
   endtask

   initial begin
      u_if.raw_i = 8'h0F;
      u_if.en_i  = 1'b1;
      rstn       = 1'b0;

      // Reset, then inverted idle pattern held
      add(8'h0F, 1, 0, 8'h00, 8'h00, 8'h00, 2);
      add(8'h0F, 1, 1, 8'h00, 8'h00, 8'h00, 20);
      // raw[4] rises: level and rise pulse six edges later
      add(8'h1F, 1, 1, 8'h00, 8'h00, 8'h00, 5);
      add(8'h1F, 1, 1, 8'h10, 8'h10, 8'h00, 1);
      add(8'h1F, 1, 1, 8'h10, 8'h00, 8'h00, 3);
      // One-edge reset mid-run clears everything, then the held input re-qualifies
      add(8'h1F, 1, 0, 8'h00, 8'h00, 8'h00, 1);
      add(8'h1F, 1, 1, 8'h00, 8'h00, 8'h00, 5);
      add(8'h1F, 1, 1, 8'h10, 8'h10, 8'h00, 1);
      add(8'h1F, 1, 1, 8'h10, 8'h00, 8'h00, 2);
      // raw[5] glitches: 1 cycle high, 5 low, 3 high, then low
      add(8'h3F, 1, 1, 8'h10, 8'h00, 8'h00, 1);
      add(8'h1F, 1, 1, 8'h10, 8'h00, 8'h00, 5);
      add(8'h3F, 1, 1, 8'h10, 8'h00, 8'h00, 3);
      add(8'h1F, 1, 1, 8'h10, 8'h00, 8'h00, 8);
      // raw[0] active-low press then release
      add(8'h1E, 1, 1, 8'h10, 8'h00, 8'h00, 5);
      add(8'h1E, 1, 1, 8'h11, 8'h01, 8'h00, 1);
      add(8'h1E, 1, 1, 8'h11, 8'h00, 8'h00, 2);
      add(8'h1F, 1, 1, 8'h11, 8'h00, 8'h00, 5);
      add(8'h1F, 1, 1, 8'h10, 8'h00, 8'h01, 1);
      add(8'h1F, 1, 1, 8'h10, 8'h00, 8'h00, 2);
      // raw[7:6] rise together
      add(8'hDF, 1, 1, 8'h10, 8'h00, 8'h00, 5);
      add(8'hDF, 1, 1, 8'hD0, 8'hC0, 8'h00, 1);
      add(8'hDF, 1, 1, 8'hD0, 8'h00, 8'h00, 2);
      // raw[4] drops while disabled, then re-enable: four edges to accept
      add(8'hCF, 0, 1, 8'hD0, 8'h00, 8'h00, 10);
      add(8'hCF, 1, 1, 8'hD0, 8'h00, 8'h00, 3);
      add(8'hCF, 1, 1, 8'hC0, 8'h00, 8'h10, 1);
      add(8'hCF, 1, 1, 8'hC0, 8'h00, 8'h00, 2);

      foreach (vecs[i]) begin
         step(vecs[i].raw, vecs[i].en, vecs[i].rstn);
         chk_all($sformatf("row%0d", i), vecs[i].lvl, vecs[i].rise, vecs[i].fall);
      end

      // en_i dropped mid-count discards the partial count
      step(8'hCD, 1, 1);
      step(8'hCD, 1, 1);
      step(8'hCD, 1, 1);
      step(8'hCD, 1, 1);
      chk_all("en_mid cnt2", 8'hC0, 8'h00, 8'h00);
      step(8'hCD, 0, 1);
      chk_all("en_mid off", 8'hC0, 8'h00, 8'h00);
      for (int k = 0; k < 3; k++) begin
         step(8'hCD, 1, 1);
         chk_all($sformatf("en_mid re%0d", k + 1), 8'hC0, 8'h00, 8'h00);
      end
      step(8'hCD, 1, 1);
      chk_all("en_mid accept", 8'hC2, 8'h02, 8'h00);
      step(8'hCD, 1, 1);
      chk_all("en_mid after", 8'hC2, 8'h00, 8'h00);

      // Reset mid-count clears levels; held inputs then re-qualify from scratch
      for (int k = 0; k < 4; k++) step(8'hCF, 1, 1);
      chk_all("rst_mid cnt2", 8'hC2, 8'h00, 8'h00);
      step(8'hCF, 1, 0);
      chk_all("rst_mid rst", 8'h00, 8'h00, 8'h00);
      for (int k = 0; k < 5; k++) begin
         step(8'hCF, 1, 1);
         chk_all($sformatf("rst_mid wait%0d", k + 1), 8'h00, 8'h00, 8'h00);
      end
      step(8'hCF, 1, 1);
      chk_all("rst_mid accept", 8'hC0, 8'hC0, 8'h00);
      step(8'hCF, 1, 1);
      chk_all("rst_mid after", 8'hC0, 8'h00, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
